// File: rtl/dbus_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : dbus_pkg                                                       |
// | Brief   : Shared constants and helpers for the CPU data-bus decoder:     |
// |           error read data, default SoC address map, window match.        |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package dbus_pkg;

    // Read data returned on an error completion (unmapped or timed-out access)
    localparam logic [31:0] c_ERR_DATA = 32'hDEADBEEF;

    // Default SoC slave windows (base / compare mask)
    localparam logic [31:0] c_BIOS_BASE   = 32'h1FC00000;
    localparam logic [31:0] c_BIOS_MASK   = 32'h1FFFC000;
    localparam logic [31:0] c_CVRAM_BASE  = 32'h1FC04000;
    localparam logic [31:0] c_CVRAM_MASK  = 32'h1FFFC000;
    localparam logic [31:0] c_GVRAM_BASE  = 32'h1FE00000;
    localparam logic [31:0] c_GVRAM_MASK  = 32'h1FE00000;
    localparam logic [31:0] c_GPIO_BASE   = 32'h1FC09000;
    localparam logic [31:0] c_GPIO_MASK   = 32'h1FFFFF00;
    localparam logic [31:0] c_SDCTRL_BASE = 32'h1FC09100;
    localparam logic [31:0] c_SDCTRL_MASK = 32'h1FFFFF00;
    localparam logic [31:0] c_SDDATA_BASE = 32'h1FC08000;
    localparam logic [31:0] c_SDDATA_MASK = 32'h1FFFF000;
    localparam logic [31:0] c_SRAM_BASE   = 32'h1F000000;
    localparam logic [31:0] c_SRAM_MASK   = 32'h1FC00000;

    localparam int c_SOC_NSLV = 7;

    // Slot 0 sits in the least significant 32 bits, so BIOS has top priority
    localparam logic [c_SOC_NSLV*32-1:0] c_SOC_ADDR_BASE = {
        c_SRAM_BASE, c_SDDATA_BASE, c_SDCTRL_BASE, c_GPIO_BASE,
        c_GVRAM_BASE, c_CVRAM_BASE, c_BIOS_BASE
    };
    localparam logic [c_SOC_NSLV*32-1:0] c_SOC_ADDR_MASK = {
        c_SRAM_MASK, c_SDDATA_MASK, c_SDCTRL_MASK, c_GPIO_MASK,
        c_GVRAM_MASK, c_CVRAM_MASK, c_BIOS_MASK
    };

    // True when the address falls inside the window described by base/mask
    function automatic logic addr_match(
        input logic [31:0] addr,
        input logic [31:0] base,
        input logic [31:0] mask
    );
        return (addr & mask) == base;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dbus_addr_decode.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : dbus_addr_decode                                               |
// | Brief   : Combinational priority address decoder. Lowest slot index     |
// |           wins on overlapping windows; flags unmapped requests.          |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module dbus_addr_decode
    import dbus_pkg::*;
#(
    parameter int                 NSLV      = 7,
    parameter logic [NSLV*32-1:0] ADDR_BASE = c_SOC_ADDR_BASE,
    parameter logic [NSLV*32-1:0] ADDR_MASK = c_SOC_ADDR_MASK
) (
    input  logic [31:0]     addrBus,
    input  logic            masterEN,
    output logic [NSLV-1:0] slvEN,
    output logic            miss
);

    logic [NSLV-1:0] w_hit;

    for (genvar i = 0; i < NSLV; i++) begin : g_hit
        assign w_hit[i] = addr_match(addrBus, ADDR_BASE[32*i +: 32], ADDR_MASK[32*i +: 32]);
    end

    // Isolating the lowest set hit bit gives the priority winner in one step
    assign slvEN = masterEN ? (w_hit & (~w_hit + NSLV'(1))) : '0;
    assign miss  = masterEN & ~(|w_hit);

endmodule
`default_nettype wire

// File: rtl/dbus_decoder_n.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : dbus_decoder_n                                                 |
// | Brief   : Parametrised CPU data-bus decoder/multiplexer with priority    |
// |           window resolution, unmapped-address error response and a      |
// |           stall timeout that force-completes a hung access.             |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module dbus_decoder_n
    import dbus_pkg::*;
#(
    parameter int                 NSLV      = 7,
    parameter int                 DW        = 32,
    parameter logic [NSLV*32-1:0] ADDR_BASE = c_SOC_ADDR_BASE,
    parameter logic [NSLV*32-1:0] ADDR_MASK = c_SOC_ADDR_MASK,
    parameter int                 TIMEOUT   = 255,
    parameter logic [DW-1:0]      ERR_DATA  = DW'(c_ERR_DATA)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          addrBus,
    input  logic                 masterEN,
    output logic [DW-1:0]        dataToCPU,
    output logic                 nakDBus,
    output logic                 busErr,
    output logic [31:0]          errAddr,
    output logic [7:0]           errCnt,
    output logic [NSLV-1:0]      slvEN,
    input  logic [NSLV*DW-1:0]   slvData,
    input  logic [NSLV-1:0]      slvNak
);

    // Counter is kept at least one bit wide so TIMEOUT=0 still elaborates
    localparam int              c_CW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [c_CW-1:0] c_TMAX = c_CW'(TIMEOUT);

    logic [NSLV-1:0] r_sel;
    logic            r_miss;
    logic [31:0]     r_addr;
    logic [c_CW-1:0] r_cnt;
    logic [31:0]     r_errAddr;
    logic [7:0]      r_errCnt;

    logic            w_miss;
    logic            w_dataPhase;
    logic            w_tout;
    logic [DW-1:0]   w_rdData;

    dbus_addr_decode #(
        .NSLV      (NSLV),
        .ADDR_BASE (ADDR_BASE),
        .ADDR_MASK (ADDR_MASK)
    ) u_decode (
        .addrBus  (addrBus),
        .masterEN (masterEN),
        .slvEN    (slvEN),
        .miss     (w_miss)
    );

    // Data-phase state decode: TOUT overrides the stall so the access completes
    assign w_dataPhase = |r_sel;
    assign w_tout      = w_dataPhase && (TIMEOUT != 0) && (r_cnt == c_TMAX);
    assign nakDBus     = w_dataPhase & ~w_tout & (|(r_sel & slvNak));
    assign busErr      = r_miss | w_tout;

    // One-hot AND-OR read mux; yields zero when no slave is selected
    always_comb begin
        w_rdData = '0;
        for (int i = 0; i < NSLV; i++) begin
            w_rdData = w_rdData | (slvData[DW*i +: DW] & {DW{r_sel[i]}});
        end
    end

    assign dataToCPU = busErr ? ERR_DATA : w_rdData;
    assign errAddr   = r_errAddr;
    assign errCnt    = r_errCnt;

    // Data-phase registers: accept a new request whenever the bus is not stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel  <= '0;
            r_miss <= 1'b0;
            r_addr <= '0;
            r_cnt  <= '0;
        end else if (!nakDBus) begin
            r_sel  <= slvEN;
            r_miss <= w_miss;
            r_addr <= addrBus;
            r_cnt  <= '0;
        end else if (r_cnt != c_TMAX) begin
            r_cnt  <= r_cnt + c_CW'(1);
        end
    end

    // Error log: capture the failing address and count errors with saturation
    always_ff @(posedge clk) begin
        if (rst) begin
            r_errAddr <= '0;
            r_errCnt  <= '0;
        end else if (busErr) begin
            r_errAddr <= r_addr;
            if (r_errCnt != 8'hFF) begin
                r_errCnt <= r_errCnt + 8'd1;
            end
        end
    end

endmodule
`default_nettype wire
